// File: rtl/bg_vram_fetch_demux.sv
// Round-robin VRAM read arbiter for the four BG layers, with a tag pipeline
// that routes returned VRAM data into per-BG holding registers.
module bg_vram_fetch_demux #(
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = 17,
  parameter int LATENCY = 2
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [3:0]        bg_enable_i,
  input  logic [3:0]        req_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [ADDR_W-1:0] addr2_i,
  input  logic [ADDR_W-1:0] addr3_i,
  output logic              vram_rd_o,
  output logic [ADDR_W-1:0] vram_addr_o,
  output logic [1:0]        sel_o,
  output logic [3:0]        grant_o,
  input  logic [WIDTH-1:0]  vram_data_i,
  output logic [WIDTH-1:0]  data_out0_o,
  output logic [WIDTH-1:0]  data_out1_o,
  output logic [WIDTH-1:0]  data_out2_o,
  output logic [WIDTH-1:0]  data_out3_o,
  output logic [3:0]        data_valid_o
);

  logic [3:0][ADDR_W-1:0] addr_w;
  logic [3:0][WIDTH-1:0]  data_q;
  logic [3:0]             busy_q, busy_d;
  logic [3:0]             dv_q, dv_d;
  logic [3:0]             grant_q, grant_d;
  logic [3:0]             eligible;
  logic [1:0]             rr_ptr_q, sel_q, win, idx;
  logic                   found, vram_rd_q;
  logic [ADDR_W-1:0]      vram_addr_q;
  logic [LATENCY-1:0]     tag_vld_q;
  logic [LATENCY-1:0][1:0] tag_id_q;
  logic                   ret_vld;
  logic [1:0]             ret_id;

  assign addr_w   = {addr3_i, addr2_i, addr1_i, addr0_i};
  assign eligible = req_i & bg_enable_i & ~busy_q;
  assign ret_vld  = tag_vld_q[LATENCY-1];
  assign ret_id   = tag_id_q[LATENCY-1];

  // Search starts one past the last winner and wraps back to it.
  always_comb begin
    found = 1'b0;
    win   = rr_ptr_q;
    idx   = rr_ptr_q;
    for (int i = 1; i <= 4; i++) begin
      idx = rr_ptr_q + 2'(i);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    busy_d  = busy_q;
    dv_d    = '0;
    grant_d = '0;
    // A disabled BG still frees its slot on return; only the data is dropped.
    if (ret_vld) begin
      busy_d[ret_id] = 1'b0;
      if (bg_enable_i[ret_id]) dv_d[ret_id] = 1'b1;
    end
    if (found) begin
      busy_d[win]  = 1'b1;
      grant_d[win] = 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      vram_rd_q   <= 1'b0;
      vram_addr_q <= '0;
      sel_q       <= '0;
      grant_q     <= '0;
      data_q      <= '0;
      dv_q        <= '0;
      busy_q      <= '0;
      rr_ptr_q    <= 2'd3;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
    end else begin
      vram_rd_q <= found;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      dv_q      <= dv_d;
      if (found) begin
        sel_q       <= win;
        vram_addr_q <= addr_w[win];
        rr_ptr_q    <= win;
      end
      if (ret_vld && dv_d[ret_id]) data_q[ret_id] <= vram_data_i;
      tag_vld_q[0] <= vram_rd_q;
      tag_id_q[0]  <= sel_q;
      for (int s = 1; s < LATENCY; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
    end
  end

  assign vram_rd_o    = vram_rd_q;
  assign vram_addr_o  = vram_addr_q;
  assign sel_o        = sel_q;
  assign grant_o      = grant_q;
  assign data_out0_o  = data_q[0];
  assign data_out1_o  = data_q[1];
  assign data_out2_o  = data_q[2];
  assign data_out3_o  = data_q[3];
  assign data_valid_o = dv_q;

endmodule

// File: tb/tb_bg_vram_fetch_demux.sv
// Directed bench for bg_vram_fetch_demux with a small fixed-latency VRAM model.
module tb_bg_vram_fetch_demux;
  localparam int WIDTH   = 16;
  localparam int ADDR_W  = 17;
  localparam int LATENCY = 2;

  logic              clk = 1'b0;
  logic              reset_i;
  logic [3:0]        bg_enable_i, req_i;
  logic [ADDR_W-1:0] addr0_i, addr1_i, addr2_i, addr3_i;
  logic              vram_rd_o;
  logic [ADDR_W-1:0] vram_addr_o;
  logic [1:0]        sel_o;
  logic [3:0]        grant_o;
  logic [WIDTH-1:0]  vram_data_i;
  logic [WIDTH-1:0]  data_out0_o, data_out1_o, data_out2_o, data_out3_o;
  logic [3:0]        data_valid_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bg_vram_fetch_demux #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clock_i(clk), .reset_i(reset_i), .bg_enable_i(bg_enable_i), .req_i(req_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .addr2_i(addr2_i), .addr3_i(addr3_i),
    .vram_rd_o(vram_rd_o), .vram_addr_o(vram_addr_o), .sel_o(sel_o), .grant_o(grant_o),
    .vram_data_i(vram_data_i),
    .data_out0_o(data_out0_o), .data_out1_o(data_out1_o),
    .data_out2_o(data_out2_o), .data_out3_o(data_out3_o),
    .data_valid_o(data_valid_o)
  );

  // VRAM model: address 0x00100 holds 16'hBEEF, everything else holds addr[15:0]^16'h5A5A.
  logic [LATENCY-1:0] m_vld = '0;
  logic [ADDR_W-1:0]  m_addr [LATENCY];
  always @(posedge clk) begin
    m_vld[0]  <= vram_rd_o;
    m_addr[0] <= vram_addr_o;
    for (int s = 1; s < LATENCY; s++) begin
      m_vld[s]  <= m_vld[s-1];
      m_addr[s] <= m_addr[s-1];
    end
  end
  always_comb begin
    vram_data_i = 16'hDEAD;
    if (m_vld[LATENCY-1])
      vram_data_i = (m_addr[LATENCY-1] == 17'h00100) ? 16'hBEEF
                                                     : (m_addr[LATENCY-1][15:0] ^ 16'h5A5A);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; req_i = 4'h0; bg_enable_i = 4'hF;
    tick(); tick();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (vram_rd_o !== 1'b0 || grant_o !== 4'h0 || sel_o !== 2'd0 || vram_addr_o !== '0) begin
      errors++; $display("FAIL reset_port rd=%b grant=%b sel=%0d addr=%h exp 0", vram_rd_o, grant_o, sel_o, vram_addr_o); end
    checks++; if (data_valid_o !== 4'h0 || data_out0_o !== 16'h0 || data_out1_o !== 16'h0 ||
                  data_out2_o !== 16'h0 || data_out3_o !== 16'h0) begin
      errors++; $display("FAIL reset_data dv=%b d0=%h d1=%h d2=%h d3=%h exp 0", data_valid_o,
                         data_out0_o, data_out1_o, data_out2_o, data_out3_o); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    do_reset();
    addr0_i = 17'h00010; addr1_i = 17'h00011; addr2_i = 17'h00012; addr3_i = 17'h00013;
    req_i = 4'hF;
    for (int t = 0; t < 5; t++) begin
      tick();
      checks++; if (grant_o !== exp_g[t] || vram_rd_o !== 1'b1) begin
        errors++; $display("FAIL rr_grant t=%0d grant=%b rd=%b exp %b rd=1", t+1, grant_o, vram_rd_o, exp_g[t]); end
      if (t == 3) begin
        checks++; if (data_valid_o !== 4'b0001 || data_out0_o !== 16'h5A4A) begin
          errors++; $display("FAIL rr_dv0 dv=%b d0=%h exp 0001 5a4a", data_valid_o, data_out0_o); end
      end
    end
    checks++; if (sel_o !== 2'd0 || vram_addr_o !== 17'h00010) begin
      errors++; $display("FAIL rr_regrant sel=%0d addr=%h exp 0 00010", sel_o, vram_addr_o); end
    req_i = 4'h0;
  endtask

  task automatic test_single();
    do_reset();
    addr0_i = 17'h00100; req_i = 4'b0001;
    tick();
    req_i = 4'h0;
    checks++; if (vram_rd_o !== 1'b1 || vram_addr_o !== 17'h00100 || grant_o !== 4'b0001 || sel_o !== 2'd0) begin
      errors++; $display("FAIL single_issue rd=%b addr=%h grant=%b sel=%0d exp 1 00100 0001 0",
                         vram_rd_o, vram_addr_o, grant_o, sel_o); end
    for (int t = 2; t <= LATENCY + 1; t++) begin
      tick();
      checks++; if (data_valid_o !== 4'h0 || vram_rd_o !== 1'b0) begin
        errors++; $display("FAIL single_early t=%0d dv=%b rd=%b exp 0", t, data_valid_o, vram_rd_o); end
    end
    tick();
    checks++; if (data_valid_o !== 4'b0001 || data_out0_o !== 16'hBEEF) begin
      errors++; $display("FAIL single_ret dv=%b d0=%h exp 0001 beef", data_valid_o, data_out0_o); end
    checks++; if (data_out1_o !== 16'h0 || data_out2_o !== 16'h0 || data_out3_o !== 16'h0) begin
      errors++; $display("FAIL single_others d1=%h d2=%h d3=%h exp 0", data_out1_o, data_out2_o, data_out3_o); end
    tick();
    checks++; if (data_valid_o !== 4'h0 || data_out0_o !== 16'hBEEF) begin
      errors++; $display("FAIL single_hold dv=%b d0=%h exp 0000 beef", data_valid_o, data_out0_o); end
  endtask

  task automatic test_rr_ptr();
    do_reset();
    addr1_i = 17'h00222; req_i = 4'b0010;
    tick();
    req_i = 4'h0;
    checks++; if (grant_o !== 4'b0010) begin
      errors++; $display("FAIL ptr_prime grant=%b exp 0010", grant_o); end
    tick(); tick(); tick();
    checks++; if (data_valid_o !== 4'b0010 || data_out1_o !== 16'h5878) begin
      errors++; $display("FAIL ptr_prime_ret dv=%b d1=%h exp 0010 5878", data_valid_o, data_out1_o); end
    addr1_i = 17'h00444; addr3_i = 17'h1F00F; req_i = 4'b1010;
    tick();
    req_i = 4'b0010;
    checks++; if (grant_o !== 4'b1000 || sel_o !== 2'd3 || vram_addr_o !== 17'h1F00F) begin
      errors++; $display("FAIL ptr_bg3 grant=%b sel=%0d addr=%h exp 1000 3 1f00f", grant_o, sel_o, vram_addr_o); end
    tick();
    req_i = 4'h0;
    checks++; if (grant_o !== 4'b0010 || sel_o !== 2'd1 || vram_addr_o !== 17'h00444) begin
      errors++; $display("FAIL ptr_bg1 grant=%b sel=%0d addr=%h exp 0010 1 00444", grant_o, sel_o, vram_addr_o); end
    tick(); tick();
    checks++; if (data_valid_o !== 4'b1000 || data_out3_o !== 16'hAA55 || data_out1_o !== 16'h5878) begin
      errors++; $display("FAIL ptr_ret3 dv=%b d3=%h d1=%h exp 1000 aa55 5878", data_valid_o, data_out3_o, data_out1_o); end
    tick();
    checks++; if (data_valid_o !== 4'b0010 || data_out1_o !== 16'h5E1E || data_out3_o !== 16'hAA55) begin
      errors++; $display("FAIL ptr_ret1 dv=%b d1=%h d3=%h exp 0010 5e1e aa55", data_valid_o, data_out1_o, data_out3_o); end
  endtask

  task automatic test_disable_drop();
    do_reset();
    addr2_i = 17'h00333; req_i = 4'b0100;
    tick();
    checks++; if (grant_o !== 4'b0100) begin
      errors++; $display("FAIL drop_issue grant=%b exp 0100", grant_o); end
    bg_enable_i = 4'b1011;
    for (int t = 0; t < 5; t++) begin
      tick();
      checks++; if (data_valid_o !== 4'h0 || data_out2_o !== 16'h0 || grant_o !== 4'h0) begin
        errors++; $display("FAIL drop_quiet t=%0d dv=%b d2=%h grant=%b exp 0", t, data_valid_o, data_out2_o, grant_o); end
    end
    bg_enable_i = 4'hF;
    tick();
    req_i = 4'h0;
    checks++; if (grant_o !== 4'b0100 || vram_addr_o !== 17'h00333) begin
      errors++; $display("FAIL drop_regrant grant=%b addr=%h exp 0100 00333", grant_o, vram_addr_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    addr0_i = 17'h00050; addr1_i = 17'h00051; req_i = 4'b0011;
    tick();
    checks++; if (grant_o !== 4'b0001) begin
      errors++; $display("FAIL mid_g0 grant=%b exp 0001", grant_o); end
    tick();
    checks++; if (grant_o !== 4'b0010) begin
      errors++; $display("FAIL mid_g1 grant=%b exp 0010", grant_o); end
    reset_i = 1'b1; req_i = 4'h0;
    tick();
    reset_i = 1'b0;
    checks++; if (vram_rd_o !== 1'b0 || grant_o !== 4'h0 || sel_o !== 2'd0 || vram_addr_o !== '0 ||
                  data_valid_o !== 4'h0 || data_out0_o !== 16'h0 || data_out1_o !== 16'h0) begin
      errors++; $display("FAIL mid_clear rd=%b grant=%b sel=%0d addr=%h dv=%b d0=%h d1=%h exp 0",
                         vram_rd_o, grant_o, sel_o, vram_addr_o, data_valid_o, data_out0_o, data_out1_o); end
    for (int t = 0; t < 6; t++) begin
      tick();
      checks++; if (data_valid_o !== 4'h0 || data_out0_o !== 16'h0 || data_out1_o !== 16'h0) begin
        errors++; $display("FAIL mid_quiet t=%0d dv=%b d0=%h d1=%h exp 0", t, data_valid_o, data_out0_o, data_out1_o); end
    end
  endtask

  task automatic test_all_disabled();
    do_reset();
    bg_enable_i = 4'h0; req_i = 4'hF;
    for (int t = 0; t < 10; t++) begin
      tick();
      checks++; if (vram_rd_o !== 1'b0 || grant_o !== 4'h0) begin
        errors++; $display("FAIL disabled t=%0d rd=%b grant=%b exp 0", t, vram_rd_o, grant_o); end
    end
    req_i = 4'h0; bg_enable_i = 4'hF;
  endtask

  initial begin
    reset_i = 1'b1; bg_enable_i = 4'hF; req_i = 4'h0;
    addr0_i = '0; addr1_i = '0; addr2_i = '0; addr3_i = '0;
    test_reset();
    test_round_robin();
    test_single();
    test_rr_ptr();
    test_disable_drop();
    test_reset_mid();
    test_all_disabled();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bg_vram_fetch_demux.md
Name: bg_vram_fetch_demux

Overview:
- Return-path counterpart to the BG 4:1 select path. Arbitrates round-robin among the four background layers' VRAM read requests and drives a single VRAM read port.
- Tags each issued read with its BG index and demultiplexes returned VRAM data into four per-BG holding registers with one-cycle valid strobes.
- Sits between the four BG fetch units and the VRAM read port in the BG processing circuit.

Parameters:
- WIDTH, 16, VRAM data width and width of each per-BG data output.
- ADDR_W, 17, VRAM address width.
- LATENCY, 2, cycles from vram_rd asserted to vram_data valid; legal range 1..4.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- bg_enable  input  4  per-BG enable; bit k gates BGk.
- req  input  4  per-BG read request; level, held until the matching grant bit is seen.
- addr0..addr3  input  ADDR_W each  per-BG read address, sampled with req.
- vram_rd  output  1  read strobe to VRAM, one cycle per access.
- vram_addr  output  ADDR_W  address of the current read.
- sel  output  2  index of the BG granted this cycle; mirrors the 4:1 select encoding.
- grant  output  4  one-hot grant, high in the same cycle as vram_rd.
- vram_data  input  WIDTH  VRAM read data, valid LATENCY cycles after vram_rd.
- data_out0..data_out3  output  WIDTH each  per-BG captured data, held until overwritten.
- data_valid  output  4  one-cycle strobe per BG when its data_out updates.

Behaviour:
- Reset (synchronous, checked before all other logic): vram_rd=0, vram_addr=0, sel=0, grant=0, data_out0..3=0, data_valid=0, busy=0, tag pipeline cleared, rr_ptr=3 so BG0 is searched first.
- eligible[k] = req[k] & bg_enable[k] & ~busy[k].
- Arbitration:
  - Combinational search over eligible, starting at (rr_ptr+1) mod 4 and wrapping.
  - On the winning index w at clock edge N: vram_rd=1, grant=1<<w, sel=w, vram_addr=addr_w, all registered and visible during cycle N+1. Also busy[w]=1 and rr_ptr=w.
  - With no eligible BG: vram_rd=0, grant=0, and sel/vram_addr hold their last values.
- Throughput: at most one read per cycle. At most one outstanding read per BG, enforced by busy. Back-to-back reads to different BGs are allowed every cycle.
- Tag pipeline:
  - LATENCY-stage shift register of {valid, id[1:0]}.
  - Stage 0 loads {vram_rd, sel} each cycle. The final stage aligns with vram_data.
- Return:
  - When the final stage is valid with id=k, vram_data is captured into data_out_k at that edge.
  - data_valid[k]=1 for exactly the next cycle, and busy[k] is cleared at the same edge.
  - BGk becomes eligible again in the cycle data_valid[k] is high, so a new grant can appear the cycle after.
- bg_enable[k] deasserted while BGk is in flight: busy[k] still clears at return, but data_out_k and data_valid[k] are not updated (data dropped). No new grants are issued to BGk while it is disabled.
- Requester deasserts req[k] in its grant cycle: no effect; the issued read completes normally.
- data_valid is zero-or-one-hot per cycle because returns are one per cycle.
- Reset mid-operation: in-flight tags are discarded, and no data_valid is emitted for reads issued before reset, even if vram_data arrives later.
- Addresses pass through unmodified. There is no arithmetic.

Test Plan:
- Reset, bg_enable=4'hF, req=4'hF held constantly -> grants in the order BG0,BG1,BG2,BG3 on consecutive cycles. BG0 is next granted one cycle after data_valid[0] is high (cycle 1+LATENCY+1 relative to its first grant).
- req=4'b0001 only, addr0=17'h00100, VRAM model returns 16'hBEEF -> vram_rd in cycle 1; data_valid=4'b0001 with data_out0=16'hBEEF exactly LATENCY+1 cycles after vram_rd. Other data_out registers stay 0.
- req=4'b1010, rr_ptr=1 -> BG3 granted first (sel=3, vram_addr=addr3), then BG1. Returned data lands in data_out3 and data_out1 respectively, with no cross-talk.
- BG2 granted, then bg_enable[2] cleared before return -> data_valid[2] is never asserted and data_out2 is unchanged. After bg_enable[2] is restored, BG2 is granted again.
- Reset asserted one cycle after grants to BG0 and BG1 -> all outputs are 0 on the next cycle, and no data_valid pulses appear in the following 6 cycles despite vram_data toggling.
- bg_enable=0 with req=4'hF for 10 cycles -> vram_rd=0 and grant=0 throughout.
